iq_partition_ctrl: RTL and testbench

Reconfiguration sequencer for the issue-queue payload RAM under dynamic configuration. It tracks per-partition IQ occupancy from dispatch allocations and issue frees. On a configuration request it stalls dispatch, drains partitions that are being switched off, and drives the partition-active mask into the payload RAM. It then waits for the RAM's ready signal before releasing dispatch. It sits between the dispatch/issue control logic and the payload RAM's `iqPartitionActive_i` / `payloadRamReady_o` pins.

---
 rtl/iq_partition_ctrl_pkg.sv | 32 +++
 rtl/iq_partition_ctrl_if.sv | 41 ++++
 rtl/iq_partition_ctrl_occupancy.sv | 95 +++++++++
 rtl/iq_partition_ctrl.sv | 123 ++++++++++++
 tb/tb_iq_partition_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/iq_partition_ctrl_pkg.sv
// ============================================================================
// Module : iq_partition_ctrl_pkg
// Brief  : Shared state encoding and occupancy counter sizing for the
//          issue-queue partition reconfiguration sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package iq_partition_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    GATE     = 3'd2,
    SETTLE   = 3'd3,
    WAIT_RDY = 3'd4,
    DONE     = 3'd5
  } iqPartState_t;

  localparam int IQ_DEPTH = 32;
  localparam int IQ_PARTS = 4;

  // A counter must hold 0..DEPTH/PARTS inclusive.
  function automatic int occ_cnt_width(input int depth, input int parts);
    return $clog2(depth / parts) + 1;
  endfunction

  localparam int OCC_CNT_W = occ_cnt_width(IQ_DEPTH, IQ_PARTS);

endpackage

`default_nettype wire

// File: rtl/iq_partition_ctrl_if.sv
// ============================================================================
// Module : iq_partition_ctrl_if
// Brief  : Dispatch/issue/payload-RAM signal bundle for iq_partition_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface iq_partition_ctrl_if #(
  parameter int STRUCT_PARTS   = 4,
  parameter int INDEX          = 5,
  parameter int DISPATCH_WIDTH = 4,
  parameter int ISSUE_WIDTH    = 4
);
  logic                              flush_i;
  logic                              cfgReq_i;
  logic [STRUCT_PARTS-1:0]           cfgMask_i;
  logic [DISPATCH_WIDTH-1:0]         allocValid_i;
  logic [DISPATCH_WIDTH*INDEX-1:0]   allocAddr_i;
  logic [ISSUE_WIDTH-1:0]            freeValid_i;
  logic [ISSUE_WIDTH*INDEX-1:0]      freeAddr_i;
  logic                              ramReady_i;
  logic [STRUCT_PARTS-1:0]           iqPartitionActive_o;
  logic                              stallDispatch_o;
  logic                              cfgBusy_o;
  logic                              cfgDone_o;
  logic                              illegal_o;

  modport master (
    output flush_i, cfgReq_i, cfgMask_i, allocValid_i, allocAddr_i,
           freeValid_i, freeAddr_i, ramReady_i,
    input  iqPartitionActive_o, stallDispatch_o, cfgBusy_o, cfgDone_o, illegal_o
  );

  modport slave (
    input  flush_i, cfgReq_i, cfgMask_i, allocValid_i, allocAddr_i,
           freeValid_i, freeAddr_i, ramReady_i,
    output iqPartitionActive_o, stallDispatch_o, cfgBusy_o, cfgDone_o, illegal_o
  );
endinterface

`default_nettype wire

// File: rtl/iq_partition_ctrl_occupancy.sv
// ============================================================================
// Module : iq_part_occupancy
// Brief  : Per-partition IQ occupancy counters with saturation and
//          illegal alloc/free detection.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iq_part_occupancy
  import iq_partition_ctrl_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int INDEX          = 5,
  parameter int STRUCT_PARTS   = 4,
  parameter int PART_LOG       = 2,
  parameter int DISPATCH_WIDTH = 4,
  parameter int ISSUE_WIDTH    = 4,
  parameter int CNT_W          = OCC_CNT_W
) (
  input  wire logic                                 clk,
  input  wire logic                                 reset,
  input  wire logic                                 flush,
  input  wire logic [DISPATCH_WIDTH-1:0]            alloc_valid,
  input  wire logic [DISPATCH_WIDTH*INDEX-1:0]      alloc_addr,
  input  wire logic [ISSUE_WIDTH-1:0]               free_valid,
  input  wire logic [ISSUE_WIDTH*INDEX-1:0]         free_addr,
  input  wire logic [STRUCT_PARTS-1:0]              active,
  output logic      [STRUCT_PARTS-1:0][CNT_W-1:0]   occ,
  output logic                                      illegal
);

  localparam int PART_SIZE = DEPTH / STRUCT_PARTS;
  localparam int SW        = CNT_W + 4;

  logic [STRUCT_PARTS-1:0] part_bad;

  // Only the partition field of each address matters; fold the rest away.
  logic unused_addr;
  assign unused_addr = ^{alloc_addr, free_addr};

  for (genvar p = 0; p < STRUCT_PARTS; p++) begin : g_part
    logic [SW-1:0] n_alloc;
    logic [SW-1:0] n_free;
    logic [SW-1:0] total;
    logic [SW-1:0] diff;
    logic          bad_alloc;
    logic          under;
    logic          over;

    always_comb begin
      n_alloc   = '0;
      n_free    = '0;
      bad_alloc = 1'b0;
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        if (alloc_valid[l] &&
            alloc_addr[l*INDEX+INDEX-1 -: PART_LOG] == PART_LOG'(p)) begin
          n_alloc = n_alloc + 1'b1;
          if (!active[p]) bad_alloc = 1'b1;
        end
      end
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        if (free_valid[l] &&
            free_addr[l*INDEX+INDEX-1 -: PART_LOG] == PART_LOG'(p)) begin
          n_free = n_free + 1'b1;
        end
      end
      total = SW'(occ[p]) + n_alloc;
      under = (total < n_free);
      diff  = total - n_free;
      over  = !under && (diff > SW'(PART_SIZE));
    end

    assign part_bad[p] = !flush && (under || over || bad_alloc);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        occ[p] <= '0;
      end else if (flush || under) begin
        occ[p] <= '0;
      end else if (over) begin
        occ[p] <= CNT_W'(PART_SIZE);
      end else begin
        occ[p] <= diff[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) illegal <= 1'b0;
    else        illegal <= |part_bad;
  end

endmodule

`default_nettype wire

// File: rtl/iq_partition_ctrl.sv
// ============================================================================
// Module : iq_partition_ctrl
// Brief  : Issue-queue payload RAM partition reconfiguration sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iq_partition_ctrl
  import iq_partition_ctrl_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int INDEX          = 5,
  parameter int STRUCT_PARTS   = 4,
  parameter int PART_LOG       = 2,
  parameter int DISPATCH_WIDTH = 4,
  parameter int ISSUE_WIDTH    = 4,
  parameter int SETTLE_CYCLES  = 4
) (
  input wire logic          clk,
  input wire logic          reset,
  iq_partition_ctrl_if.slave bus
);

  localparam int CNT_W = occ_cnt_width(DEPTH, STRUCT_PARTS);
  localparam int STW   = $clog2(SETTLE_CYCLES + 1);

  iqPartState_t                          state;
  logic [STRUCT_PARTS-1:0]               tgt;
  logic [STRUCT_PARTS-1:0]               part_active;
  logic [STW-1:0]                        settle;
  logic                                  stall;
  logic                                  busy;
  logic                                  done;
  logic                                  drain_ok;
  logic                                  illegal;
  logic [STRUCT_PARTS-1:0][CNT_W-1:0]    occ;

  iq_part_occupancy #(
    .DEPTH          (DEPTH),
    .INDEX          (INDEX),
    .STRUCT_PARTS   (STRUCT_PARTS),
    .PART_LOG       (PART_LOG),
    .DISPATCH_WIDTH (DISPATCH_WIDTH),
    .ISSUE_WIDTH    (ISSUE_WIDTH),
    .CNT_W          (CNT_W)
  ) u_occ (
    .clk         (clk),
    .reset       (reset),
    .flush       (bus.flush_i),
    .alloc_valid (bus.allocValid_i),
    .alloc_addr  (bus.allocAddr_i),
    .free_valid  (bus.freeValid_i),
    .free_addr   (bus.freeAddr_i),
    .active      (part_active),
    .occ         (occ),
    .illegal     (illegal)
  );

  // Only partitions being switched off need to be empty before gating.
  always_comb begin
    drain_ok = 1'b1;
    for (int p = 0; p < STRUCT_PARTS; p++) begin
      if (part_active[p] && !tgt[p] && occ[p] != '0) drain_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tgt         <= '1;
      part_active <= '1;
      settle      <= '0;
      stall       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfgReq_i) begin
            tgt   <= bus.cfgMask_i | STRUCT_PARTS'(1);
            state <= DRAIN;
            stall <= 1'b1;
            busy  <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_ok) state <= GATE;
        end
        GATE: begin
          part_active <= tgt;
          settle      <= STW'(SETTLE_CYCLES);
          state       <= SETTLE;
        end
        SETTLE: begin
          settle <= settle - 1'b1;
          if (settle == STW'(1)) state <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (bus.ramReady_i) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          stall <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.iqPartitionActive_o = part_active;
  assign bus.stallDispatch_o     = stall;
  assign bus.cfgBusy_o           = busy;
  assign bus.cfgDone_o           = done;
  assign bus.illegal_o           = illegal;

endmodule

`default_nettype wire

// File: tb/tb_iq_partition_ctrl.sv
// ============================================================================
// Module : tb_iq_partition_ctrl
// Brief  : Scoreboard bench for iq_partition_ctrl against a timeline model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_iq_partition_ctrl;

  localparam int DEPTH = 32, INDEX = 5, PARTS = 4, PART_LOG = 2;
  localparam int DW = 4, IW = 4, S = 4, PSIZE = DEPTH / PARTS;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  iq_partition_ctrl_if #(.STRUCT_PARTS(PARTS), .INDEX(INDEX),
                         .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW)) bus ();

  iq_partition_ctrl #(
    .DEPTH(DEPTH), .INDEX(INDEX), .STRUCT_PARTS(PARTS), .PART_LOG(PART_LOG),
    .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW), .SETTLE_CYCLES(S)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [PARTS-1:0] mask;
    logic             stall;
    logic             busy;
    logic             done;
    logic             illegal;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: occupancy as plain integers, sequence as cycle timestamps.
  int               counts[PARTS];
  logic [PARTS-1:0] m_mask, m_tgt;
  bit               in_seq, draining, done_now;
  int               cyc, gate_cyc, rdy_cyc;

  function automatic exp_t reset_exp();
    exp_t e;
    e = '0;
    e.mask = '1;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s.mask    = bus.iqPartitionActive_o;
    s.stall   = bus.stallDispatch_o;
    s.busy    = bus.cfgBusy_o;
    s.done    = bus.cfgDone_o;
    s.illegal = bus.illegal_o;
    return s;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got mask=%b stall=%b busy=%b done=%b illegal=%b, expected mask=%b stall=%b busy=%b done=%b illegal=%b",
               name, $time, act.mask, act.stall, act.busy, act.done, act.illegal,
               e.mask, e.stall, e.busy, e.done, e.illegal);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < PARTS; p++) counts[p] = 0;
    m_mask = '1; m_tgt = '1;
    in_seq = 0; draining = 0; done_now = 0;
    gate_cyc = -1; rdy_cyc = 0;
  endtask

  // Drives one cycle of stimulus and pushes the outputs expected after its edge.
  task automatic step(input logic fl, input logic rq, input logic [PARTS-1:0] cm,
                      input logic [DW-1:0] av, input logic [DW*INDEX-1:0] aa,
                      input logic [IW-1:0] fv, input logic [IW*INDEX-1:0] fa,
                      input logic rdy);
    exp_t e;
    int   na[PARTS], nf[PARTS], newc[PARTS];
    bit   bad, ok;
    @(negedge clk);
    bus.flush_i = fl; bus.cfgReq_i = rq; bus.cfgMask_i = cm;
    bus.allocValid_i = av; bus.allocAddr_i = aa;
    bus.freeValid_i = fv; bus.freeAddr_i = fa; bus.ramReady_i = rdy;

    for (int p = 0; p < PARTS; p++) begin na[p] = 0; nf[p] = 0; end
    for (int l = 0; l < DW; l++) if (av[l]) na[aa[l*INDEX+INDEX-1 -: PART_LOG]]++;
    for (int l = 0; l < IW; l++) if (fv[l]) nf[fa[l*INDEX+INDEX-1 -: PART_LOG]]++;
    bad = 0;
    for (int p = 0; p < PARTS; p++) begin
      int n;
      n = counts[p] + na[p] - nf[p];
      if (n < 0)          begin n = 0;     bad = 1; end
      else if (n > PSIZE) begin n = PSIZE; bad = 1; end
      if (na[p] > 0 && !m_mask[p]) bad = 1;
      newc[p] = fl ? 0 : n;
    end
    e = '0;
    e.illegal = fl ? 1'b0 : bad;

    ok = 1;
    for (int p = 0; p < PARTS; p++)
      if (m_mask[p] && !m_tgt[p] && counts[p] != 0) ok = 0;

    e.busy = in_seq;
    if (!in_seq) begin
      if (rq) begin
        in_seq = 1; draining = 1; m_tgt = cm | PARTS'(1); e.busy = 1;
      end
    end else if (done_now) begin
      in_seq = 0; done_now = 0; e.busy = 0;
    end else if (draining) begin
      if (ok) begin draining = 0; gate_cyc = cyc + 1; rdy_cyc = cyc + 2 + S; end
    end else if (cyc == gate_cyc) begin
      m_mask = m_tgt;
    end else if (cyc >= rdy_cyc && rdy) begin
      done_now = 1; e.done = 1;
    end
    for (int p = 0; p < PARTS; p++) counts[p] = newc[p];
    e.mask  = m_mask;
    e.stall = e.busy;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, '0, '0, rdy);
  endtask

  task automatic req(input logic [PARTS-1:0] cm);
    step(0, 1, cm, '0, '0, '0, '0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", sample(), e);
      end
    end
  end

  initial begin : stim
    logic [DW-1:0]       av;
    logic [DW*INDEX-1:0] aa;
    logic [IW-1:0]       fv;
    logic [IW*INDEX-1:0] fa;
    logic                fl;
    bus.flush_i = 0; bus.cfgReq_i = 0; bus.cfgMask_i = '0;
    bus.allocValid_i = '0; bus.allocAddr_i = '0;
    bus.freeValid_i = '0; bus.freeAddr_i = '0; bus.ramReady_i = 1;
    model_reset();
    cyc = 0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", sample(), reset_exp());
    @(negedge clk) reset = 1'b1;

    // Empty drain with a 0011 request, then restore all partitions.
    req(4'b0011); idle(10, 1);
    req(4'b1111); idle(10, 1);
    // Entries 24 and 25 resident in partition 3, then drain them one by one.
    step(0, 0, '0, 4'b0011, {5'd0, 5'd0, 5'd25, 5'd24}, '0, '0, 1);
    req(4'b0111); idle(3, 1);
    step(0, 0, '0, '0, '0, 4'b0001, {15'd0, 5'd24}, 1);
    idle(2, 1);
    step(0, 0, '0, '0, '0, 4'b0001, {15'd0, 5'd25}, 1);
    idle(10, 1);
    // Request 0000 maps to 0001.
    req(4'b0000); idle(10, 1);
    // Ready held low for 5 WAIT_RDY cycles, with an ignored mid-sequence request.
    req(4'b0001); idle(3, 1);
    step(0, 1, 4'b1111, '0, '0, '0, '0, 0);
    idle(7, 0); idle(5, 1);
    // Alloc into a gated partition, then free from an empty one.
    step(0, 0, '0, 4'b0001, {15'd0, 5'd30}, '0, '0, 1);
    step(0, 0, '0, '0, '0, 4'b0001, {15'd0, 5'd9}, 1);
    idle(2, 1);
    // Partition 2 with three entries; flush during DRAIN.
    step(0, 0, '0, 4'b0001, {15'd0, 5'd30}, 4'b0001, {15'd0, 5'd30}, 1);
    req(4'b1111); idle(10, 1);
    step(0, 0, '0, 4'b0111, {5'd0, 5'd18, 5'd17, 5'd16}, '0, '0, 1);
    req(4'b0011); idle(2, 1);
    step(1, 0, '0, '0, '0, '0, '0, 1);
    idle(12, 1);

    // Randomized traffic and requests.
    for (int i = 0; i < 3000; i++) begin
      fl = ($urandom_range(0, 49) == 0);
      av = '0; fv = '0; aa = '0; fa = '0;
      for (int l = 0; l < DW; l++) aa[l*INDEX +: INDEX] = INDEX'($urandom_range(0, DEPTH-1));
      for (int l = 0; l < IW; l++) fa[l*INDEX +: INDEX] = INDEX'($urandom_range(0, DEPTH-1));
      if (!fl && !in_seq) av = DW'($urandom) & DW'($urandom);
      if (!fl) fv = IW'($urandom) & IW'($urandom);
      step(fl, $urandom_range(0, 19) == 0, PARTS'($urandom), av, aa, fv, fa,
           $urandom_range(0, 3) != 0);
    end
    step(1, 0, '0, '0, '0, '0, '0, 1);
    idle(30, 1);

    // Asynchronous reset while in SETTLE.
    req(4'b0001); idle(4, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check("async_reset_in_settle", sample(), reset_exp());
    model_reset();
    @(negedge clk) reset = 1'b1;
    req(4'b0011); idle(12, 1);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
